pcie_traffic_gen: RTL and testbench

Parametrised, synthesizable traffic sequencer for the PCIe transaction-layer FIFO datapath (main FIFO, VC0/VC1 FIFOs, D0..Dn destination FIFOs). It runs the init handshake, pushes a deterministic LFSR packet stream into the main FIFO while honouring the main-FIFO pause, and pops destination FIFOs under a per-destination enable mask. It counts traffic and flags errors or timeouts. It sits beside the datapath under test and replaces hand-scripted stimulus sequences.

---
 rtl/pcie_traffic_gen.sv | 148 ++++++++++++++
 tb/tb_pcie_traffic_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_traffic_gen.sv
// Traffic sequencer for the PCIe transaction-layer FIFO datapath: init handshake,
// LFSR packet stream into the main FIFO, masked destination pops, run/error accounting.
module pcie_traffic_gen #(
  parameter int                DATA_W      = 6,
  parameter int                DEST_W      = 1,
  parameter int                N_PKT       = 16,
  parameter int                INIT_CYCLES = 2,
  parameter logic [DATA_W-1:0] SEED        = 6'h2B,
  parameter logic [DATA_W-1:0] TAPS        = 6'b110000,
  parameter int                TIMEOUT     = 64,
  localparam int               N_DEST      = 2 ** DEST_W,
  localparam int               CNT_W       = $clog2(N_PKT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_DEST-1:0] pop_en,
  input  logic              pause_mf,
  input  logic [N_DEST-1:0] dest_empty,
  input  logic              idle_in,
  input  logic              error_in,
  output logic              init,
  output logic              push,
  output logic [DATA_W-1:0] data_out,
  output logic [N_DEST-1:0] pop,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  output logic [CNT_W-1:0]  push_count,
  output logic [CNT_W-1:0]  pop_count
);

  localparam int IC_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SUM_W = CNT_W + DEST_W + 1;

  localparam logic [CNT_W-1:0] N_PKT_C   = CNT_W'(N_PKT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [IC_W-1:0]  INIT_LAST = IC_W'(INIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t            state_r, state_next_s;
  logic [DATA_W-1:0] lfsr_r, lfsr_next_s;
  logic [CNT_W-1:0]  push_count_r, pop_count_r, pop_next_s;
  logic [IC_W-1:0]   init_cnt_r;
  logic [TO_W-1:0]   drain_cnt_r;
  logic [SUM_W-1:0]  pop_inc_s, pop_sum_s;
  logic [N_DEST-1:0] pop_s;
  logic              push_s, fault_s, active_s;

  assign active_s    = (state_r == S_RUN) || (state_r == S_DRAIN);
  assign push_s      = (state_r == S_RUN) && !pause_mf && (push_count_r < N_PKT_C);
  assign pop_s       = active_s ? (pop_en & ~dest_empty) : {N_DEST{1'b0}};
  assign fault_s     = error_in || (pop_count_r > N_PKT_C);
  assign lfsr_next_s = {lfsr_r[DATA_W-2:0], ^(lfsr_r & TAPS)};

  // Saturating pop counter update from the number of pops this cycle
  always_comb begin
    pop_inc_s = '0;
    for (int d = 0; d < N_DEST; d++) begin
      pop_inc_s = pop_inc_s + SUM_W'(pop_s[d]);
    end
    pop_sum_s = SUM_W'(pop_count_r) + pop_inc_s;
    if (pop_sum_s > SUM_W'(CNT_MAX)) begin
      pop_next_s = CNT_MAX;
    end else begin
      pop_next_s = pop_sum_s[CNT_W-1:0];
    end
  end

  // Next-state logic; faults outrank the drain timeout, which outranks completion
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_next_s = S_INIT;
        else       state_next_s = S_IDLE;
      end
      S_INIT: begin
        if (fault_s)                        state_next_s = S_ERR;
        else if (init_cnt_r == INIT_LAST)   state_next_s = S_RUN;
        else                                state_next_s = S_INIT;
      end
      S_RUN: begin
        if (fault_s) state_next_s = S_ERR;
        else if ((push_count_r == N_PKT_C) ||
                 (push_s && (push_count_r == N_PKT_C - CNT_W'(1))))
          state_next_s = S_DRAIN;
        else
          state_next_s = S_RUN;
      end
      S_DRAIN: begin
        if (fault_s)                                   state_next_s = S_ERR;
        else if (drain_cnt_r == TO_LAST)               state_next_s = S_ERR;
        else if ((pop_count_r == N_PKT_C) && idle_in)  state_next_s = S_DONE;
        else                                           state_next_s = S_DRAIN;
      end
      S_DONE:  state_next_s = S_IDLE;
      S_ERR:   state_next_s = S_ERR;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State, LFSR and counters; counts clear on start so a finished run stays readable
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      lfsr_r       <= SEED;
      push_count_r <= '0;
      pop_count_r  <= '0;
      init_cnt_r   <= '0;
      drain_cnt_r  <= '0;
    end else begin
      state_r <= state_next_s;
      if (state_r == S_IDLE) lfsr_r <= SEED;
      else if (push_s)       lfsr_r <= lfsr_next_s;
      if ((state_r == S_IDLE) && start) begin
        push_count_r <= '0;
        pop_count_r  <= '0;
      end else begin
        if (push_s) push_count_r <= push_count_r + CNT_W'(1);
        pop_count_r <= pop_next_s;
      end
      init_cnt_r  <= (state_r == S_INIT)  ? init_cnt_r + IC_W'(1)  : '0;
      drain_cnt_r <= (state_r == S_DRAIN) ? drain_cnt_r + TO_W'(1) : '0;
    end
  end

  assign init       = (state_r == S_INIT);
  assign busy       = (state_r == S_INIT) || active_s;
  assign done       = (state_r == S_DONE);
  assign err_flag   = (state_r == S_ERR);
  assign push       = push_s;
  assign pop        = pop_s;
  assign data_out   = lfsr_r;
  assign push_count = push_count_r;
  assign pop_count  = pop_count_r;

endmodule

// File: tb/tb_pcie_traffic_gen.sv
// Self-checking bench for pcie_traffic_gen: every cycle is compared against a
// spec-level model of the run phases with per-destination FIFO occupancy.
module tb_pcie_traffic_gen;
  localparam int DATA_W      = 6;
  localparam int N_PKT       = 16;
  localparam int INIT_CYCLES = 2;
  localparam int TIMEOUT     = 64;
  localparam int CNT_MAX     = 31;
  localparam logic [5:0] SEED = 6'h2B;
  localparam logic [5:0] TAPS = 6'b110000;
  localparam int P_IDLE = 0, P_INIT = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4, P_ERR = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0, pause_mf = 1'b0, idle_in = 1'b1, error_in = 1'b0;
  logic [1:0] pop_en = 2'b11, dest_empty = 2'b11;
  logic       init, push, busy, done, err_flag;
  logic [5:0] data_out;
  logic [1:0] pop;
  logic [4:0] push_count, pop_count;

  always #5 clk = ~clk;

  pcie_traffic_gen dut (
    .clk(clk), .reset(reset), .start(start), .pop_en(pop_en), .pause_mf(pause_mf),
    .dest_empty(dest_empty), .idle_in(idle_in), .error_in(error_in), .init(init),
    .push(push), .data_out(data_out), .pop(pop), .busy(busy), .done(done),
    .err_flag(err_flag), .push_count(push_count), .pop_count(pop_count)
  );

  // stimulus knobs
  logic       k_reset = 1'b1, k_start = 1'b0, k_pause = 1'b0, k_idle = 1'b1, k_error = 1'b0;
  logic       k_force = 1'b0;
  logic [1:0] k_pop_en = 2'b11, k_empty = 2'b00;

  // reference model
  logic [5:0] seq [0:N_PKT];
  int m_phase = P_IDLE, m_init = 0, m_push = 0, m_pop = 0, m_drain = 0, m_idx = 0;
  int q_cnt [2];

  // observations from the latest check point
  logic       l_init, l_push, l_busy, l_done, l_err;
  logic [5:0] l_data;
  logic [1:0] l_pop;
  logic [4:0] l_push_count, l_pop_count;
  int obs_init, obs_push, obs_done, obs_run, obs_drain;
  logic [5:0] obs_first [2];

  int n_asserts = 0, n_fail = 0;

  function automatic logic [5:0] lfsr_step(input logic [5:0] v);
    return 6'((int'(v) * 2) % 64 + ($countones(v & TAPS) % 2));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_init = 0; obs_push = 0; obs_done = 0; obs_run = 0; obs_drain = 0;
    l_done = 1'b0; l_err = 1'b0;
  endtask

  task automatic tick();
    logic [1:0] e_pop;
    logic       e_push;
    int         pre_pop, dst;
    bit         fault;
    @(negedge clk);
    reset = k_reset; start = k_start; pause_mf = k_pause; idle_in = k_idle;
    error_in = k_error; pop_en = k_pop_en;
    dest_empty = k_force ? k_empty : {q_cnt[1] == 0, q_cnt[0] == 0};
    #1;
    e_push = (m_phase == P_RUN) && !k_pause && (m_push < N_PKT);
    e_pop  = (m_phase == P_RUN || m_phase == P_DRAIN) ? (k_pop_en & ~dest_empty) : 2'b00;
    chk("init", 32'(init), 32'(m_phase == P_INIT));
    chk("busy", 32'(busy), 32'(m_phase == P_INIT || m_phase == P_RUN || m_phase == P_DRAIN));
    chk("done", 32'(done), 32'(m_phase == P_DONE));
    chk("err_flag", 32'(err_flag), 32'(m_phase == P_ERR));
    chk("push", 32'(push), 32'(e_push));
    chk("pop", 32'(pop), 32'(e_pop));
    chk("data_out", 32'(data_out), 32'(seq[m_idx]));
    chk("push_count", 32'(push_count), 32'(m_push));
    chk("pop_count", 32'(pop_count), 32'(m_pop));
    l_init = init; l_push = push; l_busy = busy; l_done = done; l_err = err_flag;
    l_data = data_out; l_pop = pop; l_push_count = push_count; l_pop_count = pop_count;
    if (init) obs_init++;
    if (done) obs_done++;
    if (push) begin
      if (obs_push < 2) obs_first[obs_push] = data_out;
      obs_push++;
    end
    if (busy && !init && push_count < 5'd16) obs_run++;
    if (busy && push_count == 5'd16) obs_drain++;
    @(posedge clk);
    pre_pop = m_pop;
    if (k_reset) begin
      m_phase = P_IDLE; m_push = 0; m_pop = 0; m_idx = 0; m_init = 0; m_drain = 0;
      q_cnt[0] = 0; q_cnt[1] = 0;
    end else begin
      fault = k_error || (pre_pop > N_PKT);
      if (e_push) begin
        dst = int'(seq[m_idx][DATA_W-2]);
        q_cnt[dst]++;
        m_idx++;
        m_push++;
      end
      for (int d = 0; d < 2; d++) if (e_pop[d] && q_cnt[d] > 0) q_cnt[d]--;
      m_pop = (m_pop + $countones(e_pop) > CNT_MAX) ? CNT_MAX : m_pop + $countones(e_pop);
      case (m_phase)
        P_IDLE: begin
          m_idx = 0;
          if (k_start) begin m_phase = P_INIT; m_init = 0; m_push = 0; m_pop = 0; end
        end
        P_INIT: if (fault) m_phase = P_ERR;
                else begin m_init++; if (m_init == INIT_CYCLES) m_phase = P_RUN; end
        P_RUN:  if (fault) m_phase = P_ERR;
                else if (m_push == N_PKT) begin m_phase = P_DRAIN; m_drain = 0; end
        P_DRAIN: if (fault) m_phase = P_ERR;
                 else begin
                   m_drain++;
                   if (m_drain == TIMEOUT) m_phase = P_ERR;
                   else if (pre_pop == N_PKT && k_idle) m_phase = P_DONE;
                 end
        P_DONE: m_phase = P_IDLE;
        default: ;
      endcase
    end
  endtask

  task automatic do_reset();
    k_reset = 1'b1; tick(); k_reset = 1'b0; tick();
  endtask

  task automatic kick();
    k_start = 1'b1; tick(); k_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int npause, pc0;
    seq[0] = SEED;
    for (int k = 1; k <= N_PKT; k++) seq[k] = lfsr_step(seq[k-1]);
    q_cnt[0] = 0; q_cnt[1] = 0;
    clear_obs();

    // reset state
    tick(); tick();
    chk("rst_data_out", 32'(l_data), 32'h2B);
    chk("rst_busy", 32'(l_busy), 32'd0);
    chk("rst_counts", 32'({l_push_count, l_pop_count}), 32'd0);
    k_reset = 1'b0; tick();

    // plain run, no pause, both destinations drained
    clear_obs(); kick();
    for (int i = 0; i < 200 && !l_done; i++) tick();
    tick(); tick();
    chk("s1_init_cycles", 32'(obs_init), 32'd2);
    chk("s1_pushes", 32'(obs_push), 32'd16);
    chk("s1_run_len", 32'(obs_run), 32'd16);
    chk("s1_done_pulses", 32'(obs_done), 32'd1);
    chk("s1_first_data", 32'(obs_first[0]), 32'h2B);
    chk("s1_second_data", 32'(obs_first[1]), 32'h17);
    chk("s1_pop_count_hold", 32'(l_pop_count), 32'd16);

    // five-cycle pause after the fifth push
    do_reset(); clear_obs(); npause = 0; kick();
    for (int i = 0; i < 200 && !l_done; i++) begin
      k_pause = (m_phase == P_RUN && m_push == 5 && npause < 5);
      if (k_pause) npause++;
      tick();
      if (k_pause) chk("s2_data_frozen", 32'(l_data), 32'(seq[5]));
    end
    k_pause = 1'b0;
    chk("s2_run_len", 32'(obs_run), 32'd21);
    chk("s2_pushes", 32'(obs_push), 32'd16);
    chk("s2_done_pulses", 32'(obs_done), 32'd1);

    // randomized pause, pop masks and idle
    for (int r = 0; r < 3; r++) begin
      do_reset(); clear_obs(); kick();
      for (int i = 0; i < 400 && !l_done && !l_err; i++) begin
        if (m_phase == P_RUN) begin
          k_pause  = ($urandom_range(0, 3) == 0);
          k_pop_en = 2'($urandom_range(0, 3));
        end else begin
          k_pause  = 1'b0;
          k_pop_en = 2'b11;
        end
        k_idle = ($urandom_range(0, 9) < 7);
        tick();
      end
      k_pause = 1'b0; k_pop_en = 2'b11; k_idle = 1'b1;
      chk("s3_done_pulses", 32'(obs_done), 32'd1);
      chk("s3_pushes", 32'(obs_push), 32'd16);
    end

    // D1 never drains: timeout after 64 DRAIN cycles, then stuck in ERR
    do_reset(); clear_obs(); k_pop_en = 2'b01; kick();
    for (int i = 0; i < 300 && !l_err; i++) tick();
    chk("s4_err", 32'(l_err), 32'd1);
    chk("s4_drain_len", 32'(obs_drain), 32'd64);
    k_start = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    k_start = 1'b0;
    chk("s4_stuck_err", 32'(l_err), 32'd1);
    chk("s4_not_busy", 32'(l_busy), 32'd0);
    chk("s4_no_pop", 32'(l_pop), 32'd0);
    k_pop_en = 2'b11;

    // error during INIT
    do_reset(); clear_obs(); kick();
    k_error = 1'b1; tick(); k_error = 1'b0;
    tick();
    chk("s5_err", 32'(l_err), 32'd1);
    chk("s5_init_drop", 32'(l_init), 32'd0);
    chk("s5_init_cycles", 32'(obs_init), 32'd1);
    k_start = 1'b1; tick(); tick(); k_start = 1'b0; tick();
    chk("s5_start_ignored", 32'(l_busy), 32'd0);
    chk("s5_err_sticky", 32'(l_err), 32'd1);

    // reset on the 7th push
    do_reset(); clear_obs(); kick();
    for (int i = 0; i < 50 && !(m_phase == P_RUN && m_push == 6); i++) tick();
    k_reset = 1'b1; tick(); k_reset = 1'b0;
    chk("s6_push_at_reset", 32'(l_push), 32'd1);
    chk("s6_pushes", 32'(obs_push), 32'd7);
    tick();
    chk("s6_push_after", 32'(l_push), 32'd0);
    chk("s6_push_count", 32'(l_push_count), 32'd0);
    chk("s6_data_out", 32'(l_data), 32'h2B);
    chk("s6_busy", 32'(l_busy), 32'd0);

    // both destinations forced non-empty: two pops per cycle until overflow
    do_reset(); clear_obs(); k_force = 1'b1; k_empty = 2'b00; kick();
    for (int i = 0; i < 20 && m_phase != P_RUN; i++) tick();
    tick();
    pc0 = int'(l_pop_count);
    chk("s7_pop_both", 32'(l_pop), 32'd3);
    tick();
    chk("s7_pop_step", 32'(int'(l_pop_count) - pc0), 32'd2);
    for (int i = 0; i < 40 && !l_err; i++) tick();
    chk("s7_overflow_err", 32'(l_err), 32'd1);
    k_force = 1'b0;
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
